// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each op runs IDLE -> EXEC -> RESP; the result returns over a valid/ready handshake.
module alu_arbiter #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [4:0]       req_ctrl0,
    input  logic [N-1:0]     req_a0,
    input  logic [N-1:0]     req_b0,
    input  logic [4:0]       req_ctrl1,
    input  logic [N-1:0]     req_a1,
    input  logic [N-1:0]     req_b1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [N-1:0]     rsp_data,
    output logic             rsp_err,
    output logic [4:0]       alu_ctrl,
    output logic [N-1:0]     src_A,
    output logic [N-1:0]     src_B,
    input  logic [N-1:0]     alu_result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [4:0]       ctrl_q, ctrl_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             grant;
    logic             ctrl_ok;

    function automatic logic ctrl_supported(input logic [4:0] c);
        case (c)
            5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd10, 5'd11, 5'd12,
            5'd17, 5'd19, 5'd25, 5'd27, 5'd28, 5'd29, 5'd30: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        ctrl_d       = ctrl_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        op_count_d   = op_count_q;
        req_ready    = '0;
        rsp_valid    = '0;
        ctrl_ok      = ctrl_supported(ctrl_q);
        // On a tie the requester not served last wins; otherwise the lone requester.
        grant        = (&req_valid) ? ~last_grant_q : req_valid[1];

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[grant] = 1'b1;
                    owner_d          = grant;
                    ctrl_d           = grant ? req_ctrl1 : req_ctrl0;
                    a_d              = grant ? req_a1    : req_a0;
                    b_d              = grant ? req_b1    : req_b0;
                    state_d          = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = ctrl_ok ? alu_result : '0;
                rsp_err_d  = ~ctrl_ok;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    last_grant_d = owner_q;
                    op_count_d   = op_count_q + CNT_W'(1);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            ctrl_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            ctrl_q       <= ctrl_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            op_count_q   <= op_count_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign alu_ctrl = busy ? ctrl_q : '0;
    assign src_A    = busy ? a_q    : '0;
    assign src_B    = busy ? b_q    : '0;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = (state_q == RESP) & rsp_err_q;
    assign op_count = op_count_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single-cycle combinational ALU between two requesters, e.g. requester 0 = main execute stage and requester 1 = address/branch helper unit.
- Requests are arbitrated round-robin. Each granted request's control code and operands are registered and driven to the ALU, and the result is captured one cycle later.
- The result is returned to the owning requester through a valid/ready response handshake.
- The block also flags unsupported control codes and counts completed operations.

Parameters:
- N, 32, operand/result width; must match the ALU width.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester request valid; bit i = requester i.
- req_ready  output  2  per-requester accept strobe; at most one bit high.
- req_ctrl0  input  5  requester 0 ALU control code.
- req_a0  input  N  requester 0 operand A.
- req_b0  input  N  requester 0 operand B.
- req_ctrl1  input  5  requester 1 ALU control code.
- req_a1  input  N  requester 1 operand A.
- req_b1  input  N  requester 1 operand B.
- rsp_valid  output  2  per-requester response valid; at most one bit high.
- rsp_ready  input  2  per-requester response accept.
- rsp_data  output  N  captured ALU result for the current owner.
- rsp_err  output  1  high with rsp_valid when the owner's control code is unsupported.
- alu_ctrl  output  5  to ALU control input.
- src_A  output  N  to ALU operand A.
- src_B  output  N  to ALU operand B.
- alu_result  input  N  from ALU result (combinational).
- busy  output  1  high in any state other than IDLE.
- op_count  output  CNT_W  number of responses completed.

Behaviour:
- States: IDLE, EXEC, RESP. Held in IDLE while rst is high.
- Reset values (clk edge with rst=1):
  - State = IDLE, last_grant = 1 (so requester 0 wins the first tie).
  - Operand registers = 0, rsp_data = 0, rsp_err = 0, op_count = 0.
  - All outputs 0.
- Reset mid-operation: the in-flight op is dropped, no response is produced, and op_count is not incremented.
- IDLE:
  - grant = the requester with req_valid set. If both are set, grant = the one other than last_grant.
  - req_ready[grant] = 1, combinational, only in IDLE with a valid request.
  - The accept edge latches req_ctrl/a/b of the granted requester into the operand registers, records owner = grant, and moves to EXEC.
  - With no valid request, stay in IDLE.
- req_ready is never high outside IDLE. A requester must hold req_valid and its payload until it sees req_ready.
- alu_ctrl/src_A/src_B:
  - Driven from the operand registers in EXEC and RESP, stable for the whole operation.
  - Forced to 0 in IDLE.
- EXEC (exactly one cycle):
  - Capture alu_result into rsp_data.
  - rsp_err = 1 if the latched code is not one of {1,2,3,4,9,10,11,12,17,19,25,27,28,29,30}, else 0.
  - For an unsupported code, rsp_data captures 0, which is what the ALU returns for it.
  - Go to RESP.
- RESP:
  - rsp_valid[owner] = 1; rsp_data and rsp_err are held.
  - On rsp_ready[owner] = 1: last_grant = owner, op_count += 1 (wraps from 2^CNT_W-1 to 0), go to IDLE.
  - rsp_ready on the non-owner bit is ignored.
- rsp_valid/rsp_err low outside RESP. rsp_data retains its last value.
- Latency: request accepted at edge t -> rsp_valid high from cycle t+2.
- Back-to-back throughput: at best one op every 3 cycles (IDLE, EXEC, RESP).
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,...
- A requester dropping req_valid while not granted is legal; no state changes.
- busy = (state != IDLE).

Test Plan:
- Reset then req_valid=01, ctrl0=1, a0=5, b0=7:
  - req_ready=01 in the first IDLE cycle.
  - Two cycles after the accept edge: rsp_valid=01, rsp_data=12, rsp_err=0.
  - After rsp_ready=01, op_count=1.
- Both requesters valid continuously, ctrl0=2 (a0=10, b0=3), ctrl1=9 (a1=0xF0, b1=0x3C), rsp_ready=11:
  - Responses alternate 7 (req0), 0x30 (req1), 7, 0x30.
  - First grant goes to requester 0.
- ctrl0=5 (unsupported), a0=1, b0=1 -> rsp_valid=01, rsp_data=0, rsp_err=1.
- Response stall: hold rsp_ready=00 for 4 cycles in RESP:
  - rsp_valid, rsp_data and src_A/src_B are stable.
  - req_ready=00 even with req_valid=10.
  - busy=1.
- Assert rst during EXEC:
  - Next cycle state=IDLE, rsp_valid=00, op_count unchanged at 0.
  - Outputs alu_ctrl/src_A/src_B=0.
- Preload op_count to 0xFFFF (2^CNT_W-1) via 65535 completions, then one more completion -> op_count=0.
